fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the ID-stage hazard unit and consumes that unit's is_stall.
- Owns the PC register and the IF/ID pipeline latch, and drives the instruction-memory address.
- Applies stall hold, EX-stage redirect flush, and a counted halt drain on program-terminating ECALL.
- Tells the ID/EX latch when to inject a bubble.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_pc_register.sv | 21 ++
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: the canonical NOP, fetch-stage state encoding
// and the ECALL register/value pair that marks a program-terminating call.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   localparam logic [4:0]  ECALL_HALT_REG = 5'd17;
   localparam logic [31:0] ECALL_HALT_VAL = 32'd10;

   // ID uses this to decide whether a resolved ECALL should raise halt_req.
   function automatic logic is_halt_ecall(input logic [4:0] reg_num, input logic [31:0] reg_val);
      return (reg_num == ECALL_HALT_REG) && (reg_val == ECALL_HALT_VAL);
   endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter flop: loads pc_d when we is set, otherwise holds.
module pc_register
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] pc_d,
   output logic [31:0] pc_q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc_q <= RESET_PC;
      else if (we)
         pc_q <= pc_d;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC sequencing, IF/ID latch, stall/redirect handling
// and a counted drain after a halting ECALL.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          DRAIN_CYCLES = 4,
   parameter logic [31:0] NOP_INST     = fetch_stage_pkg::NOP_INST
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        is_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_dout,
   output logic [31:0] IF_ID_inst,
   output logic [31:0] IF_ID_pc,
   output logic        IF_ID_valid,
   output logic        ID_EX_bubble,
   output logic        is_halted
);

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   generate
      if (DRAIN_CYCLES < 1) begin : g_bad_drain
         $error("fetch_stage: DRAIN_CYCLES must be at least 1");
      end
   endgenerate

   fetch_state_e  state_q, state_d;
   logic [CW-1:0] drain_cnt_q, drain_cnt_d;
   logic          is_halted_q, is_halted_d;
   logic [31:0]   if_inst_q, if_inst_d;
   logic [31:0]   if_pc_q, if_pc_d;
   logic          if_valid_q, if_valid_d;
   logic [31:0]   pc_q, pc_d;
   logic          pc_we;

   pc_register #(.RESET_PC(RESET_PC)) u_pc (
      .clk   (clk),
      .reset (reset),
      .we    (pc_we),
      .pc_d  (pc_d),
      .pc_q  (pc_q)
   );

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      is_halted_d = is_halted_q;
      if_inst_d   = if_inst_q;
      if_pc_d     = if_pc_q;
      if_valid_d  = if_valid_q;
      pc_we       = 1'b0;
      pc_d        = pc_q + 32'd4;

      case (state_q)
         RUN: begin
            if (redirect_valid) begin
               // The instruction in ID is younger than the redirecting one, so it is squashed.
               pc_we      = 1'b1;
               pc_d       = redirect_pc & 32'hFFFF_FFFC;
               if_inst_d  = NOP_INST;
               if_pc_d    = 32'd0;
               if_valid_d = 1'b0;
            end else if (halt_req && !is_stall) begin
               state_d     = DRAIN;
               drain_cnt_d = CW'(DRAIN_CYCLES - 1);
               if_inst_d   = NOP_INST;
               if_pc_d     = 32'd0;
               if_valid_d  = 1'b0;
            end else if (!is_stall) begin
               pc_we      = 1'b1;
               if_inst_d  = imem_dout;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
            end
         end
         DRAIN: begin
            if_inst_d  = NOP_INST;
            if_pc_d    = 32'd0;
            if_valid_d = 1'b0;
            if (drain_cnt_q == '0) begin
               state_d     = HALTED;
               is_halted_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q - CW'(1);
            end
         end
         default: begin
            is_halted_d = 1'b1;
            if_valid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         is_halted_q <= 1'b0;
         if_inst_q   <= NOP_INST;
         if_pc_q     <= 32'd0;
         if_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         is_halted_q <= is_halted_d;
         if_inst_q   <= if_inst_d;
         if_pc_q     <= if_pc_d;
         if_valid_q  <= if_valid_d;
      end
   end

   assign imem_addr    = pc_q;
   assign IF_ID_inst   = if_inst_q;
   assign IF_ID_pc     = if_pc_q;
   assign IF_ID_valid  = if_valid_q;
   assign is_halted    = is_halted_q;
   assign ID_EX_bubble = (state_q != RUN) || (is_stall && !redirect_valid);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free-run, stall, redirect, halt drain,
// reset mid-drain and PC wrap, with hand-computed expectations.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        is_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_dout;
   logic [31:0] IF_ID_inst;
   logic [31:0] IF_ID_pc;
   logic        IF_ID_valid;
   logic        ID_EX_bubble;
   logic        is_halted;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Memory image: word at byte address a holds 32'hA + a/4 (0->A, 4->B, 8->C).
   assign imem_dout = 32'h0000_000A + (imem_addr >> 2);

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .is_stall       (is_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .imem_addr      (imem_addr),
      .imem_dout      (imem_dout),
      .IF_ID_inst     (IF_ID_inst),
      .IF_ID_pc       (IF_ID_pc),
      .IF_ID_valid    (IF_ID_valid),
      .ID_EX_bubble   (ID_EX_bubble),
      .is_halted      (is_halted)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_if(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                           input logic [31:0] pc, input logic valid);
      check_eq({tag, ".imem_addr"}, imem_addr, addr);
      check_eq({tag, ".inst"}, IF_ID_inst, inst);
      check_eq({tag, ".pc"}, IF_ID_pc, pc);
      check_eq({tag, ".valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
   endtask

   initial begin
      reset = 1'b1; is_stall = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'd0; halt_req = 1'b0;
      #2;
      check_if("reset", 32'h0, 32'h13, 32'h0, 1'b0);
      check_eq("reset.halted", {31'd0, is_halted}, 32'd0);
      check_eq("reset.bubble", {31'd0, ID_EX_bubble}, 32'd0);
      #10 reset = 1'b0;

      // Free-running fetch.
      step(); check_if("run1", 32'h4, 32'hA, 32'h0, 1'b1);
      step(); check_if("run2", 32'h8, 32'hB, 32'h4, 1'b1);

      // Two-cycle stall at pc=8.
      is_stall = 1'b1; #1;
      check_eq("stall.bubble0", {31'd0, ID_EX_bubble}, 32'd1);
      step(); check_if("stall1", 32'h8, 32'hB, 32'h4, 1'b1);
      check_eq("stall.bubble1", {31'd0, ID_EX_bubble}, 32'd1);
      step(); check_if("stall2", 32'h8, 32'hB, 32'h4, 1'b1);
      is_stall = 1'b0; #1;
      check_eq("unstall.bubble", {31'd0, ID_EX_bubble}, 32'd0);
      step(); check_if("resume", 32'hC, 32'hC, 32'h8, 1'b1);

      // Redirect wins over a simultaneous stall; target is word-aligned.
      redirect_valid = 1'b1; redirect_pc = 32'h103; is_stall = 1'b1; #1;
      check_eq("redir.bubble", {31'd0, ID_EX_bubble}, 32'd0);
      step(); redirect_valid = 1'b0; is_stall = 1'b0;
      check_if("redir", 32'h100, 32'h13, 32'h0, 1'b0);
      step(); check_if("post_redir", 32'h104, 32'h4A, 32'h100, 1'b1);

      // halt_req under stall is ignored.
      halt_req = 1'b1; is_stall = 1'b1; #1;
      check_eq("halt_stall.bubble", {31'd0, ID_EX_bubble}, 32'd1);
      step(); check_if("halt_stall", 32'h104, 32'h4A, 32'h100, 1'b1);
      is_stall = 1'b0; #1;
      check_eq("halt_run.bubble", {31'd0, ID_EX_bubble}, 32'd0);
      step(); halt_req = 1'b0; #1;
      check_if("halt_acc", 32'h104, 32'h13, 32'h0, 1'b0);
      check_eq("halt_acc.bubble", {31'd0, ID_EX_bubble}, 32'd1);
      check_eq("halt_acc.halted", {31'd0, is_halted}, 32'd0);
      for (int i = 1; i <= 3; i++) begin
         step(); check_eq($sformatf("drain%0d.halted", i), {31'd0, is_halted}, 32'd0);
      end
      step(); check_eq("drain4.halted", {31'd0, is_halted}, 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      step(); redirect_valid = 1'b0; #1;
      check_eq("halted.sticky", {31'd0, is_halted}, 32'd1);
      check_if("halted", 32'h104, 32'h13, 32'h0, 1'b0);
      check_eq("halted.bubble", {31'd0, ID_EX_bubble}, 32'd1);

      // Reset asserted asynchronously with drain_cnt=2.
      reset = 1'b1; #3 reset = 1'b0;
      halt_req = 1'b1;
      step(); halt_req = 1'b0;
      step(); #2;
      check_eq("mid_drain.bubble", {31'd0, ID_EX_bubble}, 32'd1);
      reset = 1'b1; #1;
      check_if("async_rst", 32'h0, 32'h13, 32'h0, 1'b0);
      check_eq("async_rst.halted", {31'd0, is_halted}, 32'd0);
      check_eq("async_rst.bubble", {31'd0, ID_EX_bubble}, 32'd0);
      #2 reset = 1'b0;
      step(); check_if("after_rst", 32'h4, 32'hA, 32'h0, 1'b1);

      // PC wraps modulo 2^32.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step(); redirect_valid = 1'b0; #1;
      check_eq("wrap.pre", imem_addr, 32'hFFFF_FFFC);
      step(); check_if("wrap", 32'h0, 32'h4000_0009, 32'hFFFF_FFFC, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
